ts_column_ctrl: RTL and testbench
=================================

Name: ts_column_ctrl

Overview:
- Digital sequencer that drives a ts_column macro's analog interface (switch matrix, SRAM and ADC controls) and captures its outputs.
- Converts host requests (write, read, MAC) arriving over a valid/ready handshake into timed control-signal phases.
- Returns captured SA_OUT or ADC_OUT data over a valid/ready response channel.
- Sits between the accelerator scheduler and one ts_column instance.

Parameters:
- numRows, 128 (localparam, fixed): wordlines / rows.
- numAdcBits, 4 (localparam, fixed): ADC bits per column.
- numCols, 1: columns driven.
- PCH_CYCLES, 2: precharge phase length, ≥1.
- SA_CYCLES, 1: sense phase length, ≥1.
- RST_CYCLES, 2: MAC bitline-reset phase length, ≥1.
- SETTLE_CYCLES, 4: MAC accumulate phase length, ≥1.
- CONV_CYCLES, 1: ADC conversion phase length, ≥1.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  controller can accept a request.
- req_op  in  2  00 write, 01 read, 10 MAC, 11 illegal.
- req_addr  in  7  row for write/read.
- req_wdata  in  numCols  write data.
- req_ifmap  in  numRows  binary activations for MAC.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_data  out  numAdcBits*numCols  read data (zero-extended) or ADC code.
- rsp_err  out  1  illegal op.
- VDR_SEL, VDR_SELB, VSS_SEL, VSS_SELB, VRST_SEL, VRST_SELB  out  numRows  switch-matrix selects; each *B output is the bitwise complement of its pair.
- WL  out  numRows  wordlines, one-hot or zero.
- PCH, WRITE, CSEL, SAEN  out  numCols  SRAM controls, replicated across columns.
- WR_DATA  out  numCols  write data.
- SA_OUT  in  numCols  sense-amp output.
- NF, NFB, M2A, M2AB, R2A, R2AB  out  numCols  ADC controls, each B the complement.
- ADC_OUT  in  numAdcBits*numCols  ADC output.

Behaviour:
- Registered outputs: every output is a register driven from next-state decode.
- Reset values: on RST, the next edge forces state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0.
  - All SEL, WL, PCH, WRITE, CSEL, SAEN, WR_DATA, NF, M2A and R2A are 0; all *B outputs are 1.
  - Reset mid-operation aborts the phase and drops any pending response, with the same values the next cycle.
- Accept: a request is accepted on an edge with req_valid && req_ready. req_ready=1 only in IDLE, and is deasserted the cycle after accept.
- Operand capture: req_addr, req_wdata, req_ifmap and req_op are latched on accept.
- States: IDLE, PRE, WR, SENSE, MRST, MSET, CONV, RESP.
- WRITE op: IDLE → PRE → WR → RESP.
  - PRE lasts PCH_CYCLES with PCH=1 and WL=0.
  - WR lasts 1 cycle with PCH=WRITE=CSEL=1, WL=onehot(addr), WR_DATA=wdata.
  - RESP carries rsp_data=0.
- READ op: IDLE → PRE → SENSE → RESP.
  - SENSE lasts SA_CYCLES with PCH=SAEN=CSEL=1 and WL=onehot(addr).
  - SA_OUT is sampled on the final SENSE edge into rsp_data[numCols-1:0], upper bits 0.
- MAC op: IDLE → MRST → MSET → CONV → RESP.
  - MRST lasts RST_CYCLES with VRST_SEL=all 1s and R2A=1.
  - MSET lasts SETTLE_CYCLES with VDR_SEL=ifmap, VSS_SEL=~ifmap, VRST_SEL=0 and M2A=1.
  - CONV lasts CONV_CYCLES with NF=1 and ifmap selects held; ADC_OUT is sampled on the final CONV edge.
  - WL, PCH, SAEN and WRITE stay 0 throughout the MAC op.
- Illegal op (11): IDLE → RESP directly, with rsp_err=1 and rsp_data=0.
- Outside its phase: every control is at its reset value, and phases never overlap. The cycle after accept always shows the first phase's controls.
- Phase counter: one shared down-counter, width clog2(max phase length)+1, loaded on each phase entry. The transition occurs when the counter reaches 0, so a length-N phase holds exactly N cycles.
- RESP:
  - rsp_valid=1, with rsp_data and rsp_err stable until rsp_valid && rsp_ready.
  - On that edge: rsp_valid=0, rsp_err=0, next state IDLE, req_ready=1.
  - No new request is accepted while a response is pending.
- Latency from accept edge to first rsp_valid cycle, at default parameters:
  - write = PCH_CYCLES+2 = 4 cycles.
  - read = PCH_CYCLES+SA_CYCLES+1 = 4 cycles.
  - MAC = RST+SETTLE+CONV+1 = 8 cycles.
  - illegal = 1 cycle.
- Addressing: req_addr is 7 bits, so every value addresses a valid row and there is no wrap-around.

Test Plan:
- Write addr=5 wdata=1, then read addr=5 → WL[5] is the only asserted line in WR and SENSE; WR is 1 cycle with PCH=WRITE=1; read rsp_data=4'b0001 exactly 4 cycles after accept.
- Write rows 0..3 with 1, MAC ifmap=128'hF → MRST 2 cycles (VRST_SEL all ones), MSET 4 cycles (VDR_SEL=0xF, VSS_SEL=~0xF), rsp_data equals the ADC_OUT sampled at the CONV edge, latency 8 cycles.
- req_op=2'b11 → rsp_valid 1 cycle after accept with rsp_err=1 and rsp_data=0; no analog control toggles.
- Hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_data stay stable, req_ready=0 with req_valid held high, no second accept; rsp_ready=1 gives IDLE the next cycle.
- Assert RST during the 3rd MSET cycle → next cycle all SEL=0, SELB=1, state IDLE, rsp_valid=0; a following read of addr 0 completes normally.
- Every cycle of every test → each *B output equals ~ its pair, and WL popcount ≤ 1.

Source files
------------

// File: rtl/ts_column_ctrl_if.sv
// Host-side request/response channel of the ts_column controller.
// The scheduler drives the master side, the controller owns the slave side.
interface ts_column_ctrl_if #(
  parameter int numRows    = 128,
  parameter int numCols    = 1,
  parameter int numAdcBits = 4
);
  logic                          req_valid;
  logic                          req_ready;
  logic [1:0]                    req_op;
  logic [6:0]                    req_addr;
  logic [numCols-1:0]            req_wdata;
  logic [numRows-1:0]            req_ifmap;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [numAdcBits*numCols-1:0] rsp_data;
  logic                          rsp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_ifmap, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_ifmap, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/ts_column_ctrl.sv
// ts_column_ctrl: turns write/read/MAC requests into timed control phases for
// one ts_column macro and returns the captured sense-amp or ADC result.
// All outputs are registers loaded from the decode of the next state, so the
// cycle after a transition already shows the new phase's controls.
module ts_column_ctrl #(
  parameter int  numCols       = 1,
  parameter int  PCH_CYCLES    = 2,
  parameter int  SA_CYCLES     = 1,
  parameter int  RST_CYCLES    = 2,
  parameter int  SETTLE_CYCLES = 4,
  parameter int  CONV_CYCLES   = 1,
  localparam int numRows       = 128,
  localparam int numAdcBits    = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  ts_column_ctrl_if.slave               host,
  output logic [numRows-1:0]            VDR_SEL,
  output logic [numRows-1:0]            VDR_SELB,
  output logic [numRows-1:0]            VSS_SEL,
  output logic [numRows-1:0]            VSS_SELB,
  output logic [numRows-1:0]            VRST_SEL,
  output logic [numRows-1:0]            VRST_SELB,
  output logic [numRows-1:0]            WL,
  output logic [numCols-1:0]            PCH,
  output logic [numCols-1:0]            WRITE,
  output logic [numCols-1:0]            CSEL,
  output logic [numCols-1:0]            SAEN,
  output logic [numCols-1:0]            WR_DATA,
  input  logic [numCols-1:0]            SA_OUT,
  output logic [numCols-1:0]            NF,
  output logic [numCols-1:0]            NFB,
  output logic [numCols-1:0]            M2A,
  output logic [numCols-1:0]            M2AB,
  output logic [numCols-1:0]            R2A,
  output logic [numCols-1:0]            R2AB,
  input  logic [numAdcBits*numCols-1:0] ADC_OUT
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int RSP_W   = numAdcBits * numCols;
  localparam int MAX_LEN = max2(max2(max2(PCH_CYCLES, SA_CYCLES),
                                     max2(RST_CYCLES, SETTLE_CYCLES)), CONV_CYCLES);
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] PCH_LOAD    = CNT_W'(PCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SA_LOAD     = CNT_W'(SA_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONV_LOAD   = CNT_W'(CONV_CYCLES - 1);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_MAC   = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0, PRE  = 3'd1, WR   = 3'd2, SENSE = 3'd3,
    MRST  = 3'd4, MSET = 3'd5, CONV = 3'd6, RESP  = 3'd7
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
  logic [1:0]           op_r, op_nxt_s;
  logic [6:0]           addr_r, addr_nxt_s;
  logic [numCols-1:0]   wdata_r, wdata_nxt_s;
  logic [numRows-1:0]   ifmap_r, ifmap_nxt_s;
  logic [RSP_W-1:0]     rsp_data_r, rsp_data_nxt_s;
  logic                 rsp_err_r, rsp_err_nxt_s;
  logic                 rsp_valid_r, req_ready_r;
  logic                 accept_s;

  logic [numRows-1:0]   vdr_sel_s, vss_sel_s, vrst_sel_s, wl_s;
  logic [numCols-1:0]   pch_s, write_s, csel_s, saen_s, wr_data_s, nf_s, m2a_s, r2a_s;
  logic [numRows-1:0]   vdr_sel_r, vdr_selb_r, vss_sel_r, vss_selb_r, vrst_sel_r, vrst_selb_r, wl_r;
  logic [numCols-1:0]   pch_r, write_r, csel_r, saen_r, wr_data_r;
  logic [numCols-1:0]   nf_r, nfb_r, m2a_r, m2ab_r, r2a_r, r2ab_r;

  assign accept_s = host.req_valid & req_ready_r;

  // Next-state, phase counter, operand capture and response data selection.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    op_nxt_s       = op_r;
    addr_nxt_s     = addr_r;
    wdata_nxt_s    = wdata_r;
    ifmap_nxt_s    = ifmap_r;
    rsp_data_nxt_s = rsp_data_r;
    rsp_err_nxt_s  = rsp_err_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          op_nxt_s    = host.req_op;
          addr_nxt_s  = host.req_addr;
          wdata_nxt_s = host.req_wdata;
          ifmap_nxt_s = host.req_ifmap;
          case (host.req_op)
            OP_WRITE, OP_READ: begin
              state_nxt_s = PRE;
              cnt_nxt_s   = PCH_LOAD;
            end
            OP_MAC: begin
              state_nxt_s = MRST;
              cnt_nxt_s   = RST_LOAD;
            end
            default: begin
              state_nxt_s    = RESP;
              cnt_nxt_s      = CNT_ZERO;
              rsp_data_nxt_s = {RSP_W{1'b0}};
              rsp_err_nxt_s  = 1'b1;
            end
          endcase
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PRE: begin
        if (cnt_r == CNT_ZERO) begin
          if (op_r == OP_WRITE) begin
            state_nxt_s = WR;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = SENSE;
            cnt_nxt_s   = SA_LOAD;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      WR: begin
        state_nxt_s    = RESP;
        rsp_data_nxt_s = {RSP_W{1'b0}};
        rsp_err_nxt_s  = 1'b0;
      end
      SENSE: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s    = RESP;
          rsp_data_nxt_s = {{(RSP_W-numCols){1'b0}}, SA_OUT};
          rsp_err_nxt_s  = 1'b0;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      MRST: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = MSET;
          cnt_nxt_s   = SETTLE_LOAD;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      MSET: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = CONV;
          cnt_nxt_s   = CONV_LOAD;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      CONV: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s    = RESP;
          rsp_data_nxt_s = ADC_OUT;
          rsp_err_nxt_s  = 1'b0;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      RESP: begin
        if (host.rsp_ready) begin
          state_nxt_s    = IDLE;
          rsp_data_nxt_s = {RSP_W{1'b0}};
          rsp_err_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Control values for the phase being entered; anything outside its phase stays idle.
  always_comb begin
    vdr_sel_s  = {numRows{1'b0}};
    vss_sel_s  = {numRows{1'b0}};
    vrst_sel_s = {numRows{1'b0}};
    wl_s       = {numRows{1'b0}};
    pch_s      = {numCols{1'b0}};
    write_s    = {numCols{1'b0}};
    csel_s     = {numCols{1'b0}};
    saen_s     = {numCols{1'b0}};
    wr_data_s  = {numCols{1'b0}};
    nf_s       = {numCols{1'b0}};
    m2a_s      = {numCols{1'b0}};
    r2a_s      = {numCols{1'b0}};
    case (state_nxt_s)
      PRE: pch_s = {numCols{1'b1}};
      WR: begin
        pch_s            = {numCols{1'b1}};
        write_s          = {numCols{1'b1}};
        csel_s           = {numCols{1'b1}};
        wl_s[addr_nxt_s] = 1'b1;
        wr_data_s        = wdata_nxt_s;
      end
      SENSE: begin
        pch_s            = {numCols{1'b1}};
        saen_s           = {numCols{1'b1}};
        csel_s           = {numCols{1'b1}};
        wl_s[addr_nxt_s] = 1'b1;
      end
      MRST: begin
        vrst_sel_s = {numRows{1'b1}};
        r2a_s      = {numCols{1'b1}};
      end
      MSET: begin
        vdr_sel_s = ifmap_nxt_s;
        vss_sel_s = ~ifmap_nxt_s;
        m2a_s     = {numCols{1'b1}};
      end
      CONV: begin
        vdr_sel_s = ifmap_nxt_s;
        vss_sel_s = ~ifmap_nxt_s;
        nf_s      = {numCols{1'b1}};
      end
      default: begin
        pch_s = {numCols{1'b0}};
      end
    endcase
  end

  // State, operand, response and control registers; RST forces the idle pattern.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      op_r        <= 2'b00;
      addr_r      <= 7'd0;
      wdata_r     <= {numCols{1'b0}};
      ifmap_r     <= {numRows{1'b0}};
      rsp_data_r  <= {RSP_W{1'b0}};
      rsp_err_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
      req_ready_r <= 1'b1;
      vdr_sel_r   <= {numRows{1'b0}};
      vdr_selb_r  <= {numRows{1'b1}};
      vss_sel_r   <= {numRows{1'b0}};
      vss_selb_r  <= {numRows{1'b1}};
      vrst_sel_r  <= {numRows{1'b0}};
      vrst_selb_r <= {numRows{1'b1}};
      wl_r        <= {numRows{1'b0}};
      pch_r       <= {numCols{1'b0}};
      write_r     <= {numCols{1'b0}};
      csel_r      <= {numCols{1'b0}};
      saen_r      <= {numCols{1'b0}};
      wr_data_r   <= {numCols{1'b0}};
      nf_r        <= {numCols{1'b0}};
      nfb_r       <= {numCols{1'b1}};
      m2a_r       <= {numCols{1'b0}};
      m2ab_r      <= {numCols{1'b1}};
      r2a_r       <= {numCols{1'b0}};
      r2ab_r      <= {numCols{1'b1}};
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      op_r        <= op_nxt_s;
      addr_r      <= addr_nxt_s;
      wdata_r     <= wdata_nxt_s;
      ifmap_r     <= ifmap_nxt_s;
      rsp_data_r  <= rsp_data_nxt_s;
      rsp_err_r   <= rsp_err_nxt_s;
      rsp_valid_r <= (state_nxt_s == RESP);
      req_ready_r <= (state_nxt_s == IDLE);
      vdr_sel_r   <= vdr_sel_s;
      vdr_selb_r  <= ~vdr_sel_s;
      vss_sel_r   <= vss_sel_s;
      vss_selb_r  <= ~vss_sel_s;
      vrst_sel_r  <= vrst_sel_s;
      vrst_selb_r <= ~vrst_sel_s;
      wl_r        <= wl_s;
      pch_r       <= pch_s;
      write_r     <= write_s;
      csel_r      <= csel_s;
      saen_r      <= saen_s;
      wr_data_r   <= wr_data_s;
      nf_r        <= nf_s;
      nfb_r       <= ~nf_s;
      m2a_r       <= m2a_s;
      m2ab_r      <= ~m2a_s;
      r2a_r       <= r2a_s;
      r2ab_r      <= ~r2a_s;
    end
  end

  assign host.req_ready = req_ready_r;
  assign host.rsp_valid = rsp_valid_r;
  assign host.rsp_data  = rsp_data_r;
  assign host.rsp_err   = rsp_err_r;
  assign VDR_SEL   = vdr_sel_r;
  assign VDR_SELB  = vdr_selb_r;
  assign VSS_SEL   = vss_sel_r;
  assign VSS_SELB  = vss_selb_r;
  assign VRST_SEL  = vrst_sel_r;
  assign VRST_SELB = vrst_selb_r;
  assign WL        = wl_r;
  assign PCH       = pch_r;
  assign WRITE     = write_r;
  assign CSEL      = csel_r;
  assign SAEN      = saen_r;
  assign WR_DATA   = wr_data_r;
  assign NF        = nf_r;
  assign NFB       = nfb_r;
  assign M2A       = m2a_r;
  assign M2AB      = m2ab_r;
  assign R2A       = r2a_r;
  assign R2AB      = r2ab_r;

endmodule

// File: tb/tb_ts_column_ctrl.sv
// Bench for ts_column_ctrl: directed steps followed by random transactions.
// A small SRAM/ADC model supplies SA_OUT and ADC_OUT, and the expected phase
// of every cycle is derived from the phase lengths by plain arithmetic.
module tb_ts_column_ctrl;
  localparam int PCH = 2, SA = 1, RSTC = 2, SETTLE = 4, CONVC = 1;
  localparam int P_IDLE = 0, P_PRE = 1, P_WR = 2, P_SENSE = 3,
                 P_MRST = 4, P_MSET = 5, P_CONV = 6, P_RESP = 7;

  logic         CLK, RST;
  logic [127:0] VDR_SEL, VDR_SELB, VSS_SEL, VSS_SELB, VRST_SEL, VRST_SELB, WL;
  logic         PCH_o, WRITE, CSEL, SAEN, WR_DATA, SA_OUT;
  logic         NF, NFB, M2A, M2AB, R2A, R2AB;
  logic [3:0]   ADC_OUT;
  logic [127:0] mem_v;
  logic         inv_en;
  int           checks, errors;

  ts_column_ctrl_if #(.numRows(128), .numCols(1), .numAdcBits(4)) bus ();

  ts_column_ctrl #(.numCols(1), .PCH_CYCLES(PCH), .SA_CYCLES(SA), .RST_CYCLES(RSTC),
                   .SETTLE_CYCLES(SETTLE), .CONV_CYCLES(CONVC)) dut (
    .CLK(CLK), .RST(RST), .host(bus),
    .VDR_SEL(VDR_SEL), .VDR_SELB(VDR_SELB), .VSS_SEL(VSS_SEL), .VSS_SELB(VSS_SELB),
    .VRST_SEL(VRST_SEL), .VRST_SELB(VRST_SELB), .WL(WL),
    .PCH(PCH_o), .WRITE(WRITE), .CSEL(CSEL), .SAEN(SAEN), .WR_DATA(WR_DATA),
    .SA_OUT(SA_OUT), .NF(NF), .NFB(NFB), .M2A(M2A), .M2AB(M2AB), .R2A(R2A), .R2AB(R2AB),
    .ADC_OUT(ADC_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Phase occupied in cycle k after the accept edge (k=1 is the first cycle).
  function automatic int phase_of(input logic [1:0] op, input int k);
    case (op)
      2'b00:   return (k <= PCH) ? P_PRE : (k == PCH + 1) ? P_WR : P_RESP;
      2'b01:   return (k <= PCH) ? P_PRE : (k <= PCH + SA) ? P_SENSE : P_RESP;
      2'b10:   return (k <= RSTC) ? P_MRST : (k <= RSTC + SETTLE) ? P_MSET :
                      (k <= RSTC + SETTLE + CONVC) ? P_CONV : P_RESP;
      default: return P_RESP;
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] op);
    case (op)
      2'b00:   return PCH + 2;
      2'b01:   return PCH + SA + 1;
      2'b10:   return RSTC + SETTLE + CONVC + 1;
      default: return 1;
    endcase
  endfunction

  task automatic chk_ctrl(input int ph, input logic [6:0] a, input logic wd, input logic [127:0] ifm);
    logic [127:0] wl_e, vdr_e, vss_e, vrst_e;
    logic pch_e, wrt_e, csel_e, saen_e, wdat_e, nf_e, m2a_e, r2a_e;
    wl_e = 128'd0; vdr_e = 128'd0; vss_e = 128'd0; vrst_e = 128'd0;
    pch_e = 1'b0; wrt_e = 1'b0; csel_e = 1'b0; saen_e = 1'b0;
    wdat_e = 1'b0; nf_e = 1'b0; m2a_e = 1'b0; r2a_e = 1'b0;
    case (ph)
      P_PRE:   pch_e = 1'b1;
      P_WR:    begin pch_e = 1'b1; wrt_e = 1'b1; csel_e = 1'b1; wl_e = 128'd1 << a; wdat_e = wd; end
      P_SENSE: begin pch_e = 1'b1; saen_e = 1'b1; csel_e = 1'b1; wl_e = 128'd1 << a; end
      P_MRST:  begin vrst_e = {128{1'b1}}; r2a_e = 1'b1; end
      P_MSET:  begin vdr_e = ifm; vss_e = ~ifm; m2a_e = 1'b1; end
      P_CONV:  begin vdr_e = ifm; vss_e = ~ifm; nf_e = 1'b1; end
      default: ;
    endcase
    chk($sformatf("wl_p%0d", ph), WL, wl_e);
    chk($sformatf("vdr_p%0d", ph), VDR_SEL, vdr_e);
    chk($sformatf("vss_p%0d", ph), VSS_SEL, vss_e);
    chk($sformatf("vrst_p%0d", ph), VRST_SEL, vrst_e);
    chk($sformatf("sram_p%0d", ph), 128'({PCH_o, WRITE, CSEL, SAEN, WR_DATA}),
        128'({pch_e, wrt_e, csel_e, saen_e, wdat_e}));
    chk($sformatf("adc_p%0d", ph), 128'({NF, M2A, R2A}), 128'({nf_e, m2a_e, r2a_e}));
  endtask

  // One transaction: accept, walk the expected phases, then the response.
  task automatic run_txn(input logic [1:0] op, input logic [6:0] a, input logic wd,
                         input logic [127:0] ifm, input int hold, input logic vhold,
                         input int rst_at);
    int lat, ph, n;
    logic [3:0] code, exp_d;
    n     = $countones(ifm & mem_v);
    code  = (n > 15) ? 4'd15 : 4'(n);
    lat   = lat_of(op);
    exp_d = (op == 2'b01) ? {3'b000, mem_v[a]} : (op == 2'b10) ? code : 4'd0;
    chk("req_ready_idle", 128'(bus.req_ready), 128'(1'b1));
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = a;
    bus.req_wdata = wd;   bus.req_ifmap = ifm;
    step();
    bus.req_valid = 1'b0; bus.req_op = 2'($urandom); bus.req_addr = 7'($urandom);
    bus.req_wdata = 1'($urandom);
    bus.req_ifmap = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 1; k < lat; k++) begin
      ph = phase_of(op, k);
      SA_OUT  = (ph == P_SENSE) ? mem_v[a] : ~mem_v[a];
      ADC_OUT = (ph == P_CONV) ? code : ~code;
      chk_ctrl(ph, a, wd, ifm);
      chk("rsp_valid_busy", 128'(bus.rsp_valid), 128'(1'b0));
      chk("req_ready_busy", 128'(bus.req_ready), 128'(1'b0));
      if (k == rst_at) begin
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk_ctrl(P_IDLE, a, wd, ifm);
        chk("rst_selb", VDR_SELB & VSS_SELB & VRST_SELB, {128{1'b1}});
        chk("rst_bouts", 128'({NFB, M2AB, R2AB}), 128'(3'b111));
        chk("rst_rsp", 128'({bus.rsp_valid, bus.rsp_err, bus.rsp_data}), 128'd0);
        chk("rst_ready", 128'(bus.req_ready), 128'(1'b1));
        return;
      end
      step();
    end
    if (op == 2'b00) mem_v[a] = wd;
    for (int h = 0; h <= hold; h++) begin
      bus.rsp_ready = (h == hold);
      bus.req_valid = vhold;
      bus.req_op    = 2'b00;
      SA_OUT  = ~mem_v[a];
      ADC_OUT = ~code;
      chk_ctrl(P_RESP, a, wd, ifm);
      chk("rsp_valid", 128'(bus.rsp_valid), 128'(1'b1));
      chk("rsp_data", 128'(bus.rsp_data), 128'(exp_d));
      chk("rsp_err", 128'(bus.rsp_err), 128'(op == 2'b11));
      chk("req_ready_resp", 128'(bus.req_ready), 128'(1'b0));
      step();
    end
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    chk("rsp_valid_done", 128'(bus.rsp_valid), 128'(1'b0));
    chk("rsp_err_done", 128'(bus.rsp_err), 128'(1'b0));
    chk("req_ready_done", 128'(bus.req_ready), 128'(1'b1));
    chk_ctrl(P_IDLE, a, wd, ifm);
  endtask

  // Every cycle: complementary pairs really complement and at most one wordline.
  always @(negedge CLK) begin
    if (inv_en) begin
      chk("inv_vdr", VDR_SELB ^ VDR_SEL, {128{1'b1}});
      chk("inv_vss", VSS_SELB ^ VSS_SEL, {128{1'b1}});
      chk("inv_vrst", VRST_SELB ^ VRST_SEL, {128{1'b1}});
      chk("inv_adcb", 128'({NFB ^ NF, M2AB ^ M2A, R2AB ^ R2A}), 128'(3'b111));
      chk("inv_wl", 128'($countones(WL) <= 1), 128'(1'b1));
    end
  end

  initial begin
    checks = 0; errors = 0; inv_en = 1'b0; mem_v = 128'd0;
    RST = 1'b1; SA_OUT = 1'b0; ADC_OUT = 4'd0;
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = 7'd0;
    bus.req_wdata = 1'b0; bus.req_ifmap = 128'd0; bus.rsp_ready = 1'b0;
    step();
    step();
    chk("reset_ctrl_sel", VDR_SEL | VSS_SEL | VRST_SEL | WL, 128'd0);
    chk("reset_selb", VDR_SELB & VSS_SELB & VRST_SELB, {128{1'b1}});
    chk("reset_hs", 128'({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_data}),
        128'(7'b1000000));
    chk_ctrl(P_IDLE, 7'd0, 1'b0, 128'd0);
    RST = 1'b0;
    inv_en = 1'b1;
    step();

    // Write then read row 5.
    run_txn(2'b00, 7'd5, 1'b1, 128'd0, 0, 1'b0, 0);
    run_txn(2'b01, 7'd5, 1'b0, 128'd0, 0, 1'b0, 0);
    // Rows 0..3 set, MAC over the first four activations.
    for (int r = 0; r < 4; r++) run_txn(2'b00, 7'(r), 1'b1, 128'd0, 0, 1'b0, 0);
    run_txn(2'b10, 7'd0, 1'b0, 128'hF, 0, 1'b0, 0);
    // Illegal op.
    run_txn(2'b11, 7'd9, 1'b1, 128'hFF, 0, 1'b0, 0);
    // Response back-pressure with a request waiting.
    run_txn(2'b01, 7'd3, 1'b0, 128'd0, 5, 1'b1, 0);
    // Reset during the third accumulate cycle, then a normal read of row 0.
    run_txn(2'b10, 7'd0, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, RSTC + 3);
    step();
    run_txn(2'b01, 7'd0, 1'b0, 128'd0, 0, 1'b0, 0);
    // Boundary rows.
    run_txn(2'b00, 7'd127, 1'b1, 128'd0, 0, 1'b0, 0);
    run_txn(2'b01, 7'd127, 1'b0, 128'd0, 1, 1'b0, 0);
    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      run_txn(2'($urandom_range(0, 3)), 7'($urandom), 1'($urandom),
              {$urandom, $urandom, $urandom, $urandom},
              int'($urandom_range(0, 3)), 1'($urandom), 0);
    end
    inv_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
